// File: rtl/ppa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ppa_pkg
// Brief   : gpk encoding, prefix combine operator and stage-count helper
// Rev     : 1.0  initial release
// ============================================================================
package ppa_pkg;

  typedef logic [1:0] gpk_t;

  localparam gpk_t GPK_K = 2'b00;
  localparam gpk_t GPK_P = 2'b01;
  localparam gpk_t GPK_G = 2'b11;

  // A propagate group is transparent, so the lower group's status shows through.
  function automatic gpk_t gpk_combine(input gpk_t cur, input gpk_t prev);
    return (cur == GPK_P) ? prev : cur;
  endfunction

  function automatic int ppa_nstage(input int width, input int reg_every);
    int levels;
    levels = $clog2(width);
    return (levels + reg_every - 1) / reg_every;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppa_prefix_level.sv
`default_nettype none
// ============================================================================
// Module  : ppa_prefix_level
// Brief   : one combinational Kogge-Stone level at distance DIST
// Rev     : 1.0  initial release
// ============================================================================
module ppa_prefix_level
  import ppa_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DIST  = 1
) (
  input  gpk_t [WIDTH-1:0] i_gpk,
  output gpk_t [WIDTH-1:0] o_gpk
);

  for (genvar j = 0; j < WIDTH; j++) begin : g_pos
    if (j >= DIST) begin : g_comb
      assign o_gpk[j] = gpk_combine(i_gpk[j], i_gpk[j-DIST]);
    end else begin : g_pass
      assign o_gpk[j] = i_gpk[j];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_prefix_adder
// Brief   : pipelined Kogge-Stone adder/subtractor with valid/ready stall
// Config  : define PPA_OVF_EN to add the signed-overflow output out_ovf
// Rev     : 1.0  initial release
// ============================================================================
module pipelined_prefix_adder
  import ppa_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
`ifdef PPA_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NSTAGE = ppa_nstage(WIDTH, REG_EVERY);
  localparam int NPOS   = WIDTH + 1;
  localparam int CO_LO  = WIDTH - (1 << LEVELS);

  logic                w_adv;
  logic [WIDTH-1:0]    w_b_eff;
  logic                w_cin_eff;
  gpk_t [NPOS-1:0]     w_gpk0;
  gpk_t [NPOS-1:0]     w_lin   [0:LEVELS-1];
  gpk_t [NPOS-1:0]     w_lout  [0:LEVELS-1];
  gpk_t [NPOS-1:0]     w_snext [1:NSTAGE];
  logic [WIDTH-1:0]    w_carry;
  gpk_t                w_co_grp;

  logic [NSTAGE:0]     r_vld;
  gpk_t [NPOS-1:0]     r_gpk [0:NSTAGE];
  logic [WIDTH-1:0]    r_p   [0:NSTAGE];
  logic [TAG_W-1:0]    r_tag [0:NSTAGE];

  assign w_adv    = !r_vld[NSTAGE] || out_ready;
  assign in_ready = w_adv;

  // Position 0 stands for bit -1 and carries the carry-in; position i+1 is bit i.
  always_comb begin
    w_b_eff   = in_sub ? ~in_b : in_b;
    w_cin_eff = in_sub | in_cin;
    w_gpk0[0] = w_cin_eff ? GPK_G : GPK_K;
    for (int i = 0; i < WIDTH; i++) begin
      w_gpk0[i+1] = {in_a[i] & w_b_eff[i], in_a[i] | w_b_eff[i]};
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    if (l % REG_EVERY == 0) begin : g_from_reg
      assign w_lin[l] = r_gpk[l / REG_EVERY];
    end else begin : g_from_lvl
      assign w_lin[l] = w_lout[l-1];
    end
    ppa_prefix_level #(
      .WIDTH (NPOS),
      .DIST  (1 << l)
    ) u_level (
      .i_gpk (w_lin[l]),
      .o_gpk (w_lout[l])
    );
  end

  // The final stage may own fewer than REG_EVERY levels.
  for (genvar s = 1; s <= NSTAGE; s++) begin : g_stage
    localparam int LAST = ((s * REG_EVERY < LEVELS) ? s * REG_EVERY : LEVELS) - 1;
    assign w_snext[s] = w_lout[LAST];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int s = 0; s <= NSTAGE; s++) begin
        r_gpk[s] <= '0;
        r_p[s]   <= '0;
        r_tag[s] <= '0;
      end
    end else if (w_adv) begin
      r_vld    <= {r_vld[NSTAGE-1:0], in_valid};
      r_gpk[0] <= w_gpk0;
      r_p[0]   <= in_a ^ w_b_eff;
      r_tag[0] <= in_tag;
      for (int s = 1; s <= NSTAGE; s++) begin
        r_gpk[s] <= w_snext[s];
        r_p[s]   <= r_p[s-1];
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Resolved positions are only ever G or K, so a G test yields the carry.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_carry[i] = (r_gpk[NSTAGE][i] == GPK_G);
    end
  end

  // log2 levels span WIDTH positions; a power-of-two MSB group still needs bit -1.
  if (CO_LO == 0) begin : g_co_join
    assign w_co_grp = gpk_combine(r_gpk[NSTAGE][WIDTH], r_gpk[NSTAGE][0]);
  end else begin : g_co_direct
    assign w_co_grp = r_gpk[NSTAGE][WIDTH];
  end

  assign out_valid = r_vld[NSTAGE];
  assign out_sum   = r_p[NSTAGE] ^ w_carry;
  assign out_cout  = (w_co_grp == GPK_G);
  assign out_tag   = r_tag[NSTAGE];

`ifdef PPA_OVF_EN
  logic [NSTAGE:0] r_amsb;
  logic [NSTAGE:0] r_bmsb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_amsb <= '0;
      r_bmsb <= '0;
    end else if (w_adv) begin
      r_amsb <= {r_amsb[NSTAGE-1:0], in_a[WIDTH-1]};
      r_bmsb <= {r_bmsb[NSTAGE-1:0], w_b_eff[WIDTH-1]};
    end
  end

  assign out_ovf = (r_amsb[NSTAGE] == r_bmsb[NSTAGE]) &&
                   (out_sum[WIDTH-1] != r_amsb[NSTAGE]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipelined_prefix_adder
// Brief   : directed and randomised checks of pipelined_prefix_adder;
//           out_ovf checks are active when PPA_OVF_EN is defined
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipelined_prefix_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, out_cout;
  logic [31:0] a, b, out_sum;
  logic [3:0]  tag, out_tag;
  logic        ovf;

  logic       v1, v3, rdy1, rdy3, ov1, ov3, co1, co3, cin8, sub8, ordy8;
  logic [7:0] a8, b8, s1, s3;
  logic [3:0] tag8, t1, t3;
  logic       ovf1, ovf3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_prefix_adder #(.WIDTH(32), .REG_EVERY(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(a), .in_b(b), .in_cin(cin), .in_sub(sub), .in_tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_tag(out_tag)
`ifdef PPA_OVF_EN
    , .out_ovf(ovf)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(8), .REG_EVERY(1), .TAG_W(4)) u_w8r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_a(a8), .in_b(b8), .in_cin(cin8), .in_sub(sub8), .in_tag(tag8),
    .out_valid(ov1), .out_ready(ordy8), .out_sum(s1),
    .out_cout(co1), .out_tag(t1)
`ifdef PPA_OVF_EN
    , .out_ovf(ovf1)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(8), .REG_EVERY(3), .TAG_W(4)) u_w8r3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3),
    .in_a(a8), .in_b(b8), .in_cin(cin8), .in_sub(sub8), .in_tag(tag8),
    .out_valid(ov3), .out_ready(ordy8), .out_sum(s3),
    .out_cout(co3), .out_tag(t3)
`ifdef PPA_OVF_EN
    , .out_ovf(ovf3)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", nm, obs, exp);
    end
  endtask

  // Issues one op into an empty pipe and checks it appears exactly 4 cycles later.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic tcin,
                        input logic tsub, input logic [3:0] ttag,
                        input logic [31:0] esum, input logic ecout);
    @(posedge clk); #1;
    a = ta; b = tb2; cin = tcin; sub = tsub; tag = ttag;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("latency_early", 64'(out_valid), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("valid", 64'(out_valid), 64'd1);
    chk("sum",   64'(out_sum),   64'(esum));
    chk("cout",  64'(out_cout),  64'(ecout));
    chk("tag",   64'(out_tag),   64'(ttag));
  endtask

  function automatic logic [12:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic s, input logic [3:0] t);
    logic [8:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + 9'd1;
    else   r = {1'b0, x} + {1'b0, y} + {8'd0, ci};
    return {t, r};
  endfunction

  logic [12:0] q1[$];
  logic [12:0] q3[$];
  int sent, got, cyc, acc1, acc3, ret1, ret3;
  logic prev_stall;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag = '0; ovf = 1'b0;
    v1 = 1'b0; v3 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0;
    cin8 = 1'b0; sub8 = 1'b0; tag8 = '0; ovf1 = 1'b0; ovf3 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum",   64'(out_sum),   64'd0);
    chk("rst_out_cout",  64'(out_cout),  64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed arithmetic
    run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 4'd1, 32'h0000_0000, 1'b1);
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 4'd2, 32'hFFFF_FFFE, 1'b0);
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 4'd3, 32'd2, 1'b1);
    run_op(32'd7, 32'd5, 1'b1, 1'b1, 4'd4, 32'd2, 1'b1);
    run_op(32'd5, 32'd7, 1'b1, 1'b1, 4'd5, 32'hFFFF_FFFE, 1'b0);
    run_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 4'd6, 32'h2143_6587, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'd7, 32'h0, 1'b1);
    run_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 4'd8, 32'h0, 1'b1);

`ifdef PPA_OVF_EN
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd9, 32'h8000_0000, 1'b0);
    chk("ovf_pos", 64'(ovf), 64'd1);
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 4'd10, 32'h7FFF_FFFF, 1'b1);
    chk("ovf_neg", 64'(ovf), 64'd1);
    run_op(32'd1, 32'd1, 1'b0, 1'b0, 4'd11, 32'd2, 1'b0);
    chk("ovf_none", 64'(ovf), 64'd0);
`endif

    // Stream 8 ops under a 1,0,0 out_ready pattern
    @(posedge clk); #1;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0;
    while (got < 8 && cyc < 200) begin
      in_valid  = (sent < 8);
      a = 32'(sent); b = 32'(sent) << 8; cin = 1'b0; sub = 1'b0; tag = 4'(sent);
      out_ready = (cyc % 3 == 0);
      @(negedge clk);
      if (prev_stall) chk("hold_valid", 64'(out_valid), 64'd1);
      if (out_valid) begin
        chk("stream_tag", 64'(out_tag), 64'(got));
        chk("stream_sum", 64'(out_sum), 64'(got * 257));
      end
      prev_stall = out_valid && !out_ready;
      if (out_valid && out_ready) got++;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_count", 64'(got), 64'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("stream_no_dup", 64'(out_valid), 64'd0);
    end

    // Reset with 3 ops in flight
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'(i + 100); b = 32'd1; tag = 4'(i + 12);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_tag",   64'(out_tag),   64'd0);
    chk("flush_sum",   64'(out_sum),   64'd0);
    repeat (6) begin
      @(negedge clk);
      chk("flush_no_stale", 64'(out_valid), 64'd0);
    end
    run_op(32'd40, 32'd2, 1'b0, 1'b0, 4'd9, 32'd42, 1'b0);

    // WIDTH=8 instances with random flow control against a reference model
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc1 = 0; acc3 = 0; ret1 = 0; ret3 = 0; cyc = 0;
    while ((ret1 < 1000 || ret3 < 1000) && cyc < 20000) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      sub8 = 1'($urandom); tag8 = 4'($urandom);
      v1 = (acc1 < 1000) && ($urandom_range(0, 3) != 0);
      v3 = (acc3 < 1000) && ($urandom_range(0, 3) != 0);
      ordy8 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (ov1 && ordy8) begin
        chk("w8r1_expected_pending", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          chk("w8r1_result", 64'({t1, co1, s1}), 64'(q1.pop_front()));
          ret1++;
        end
      end
      if (ov3 && ordy8) begin
        chk("w8r3_expected_pending", 64'(q3.size() != 0), 64'd1);
        if (q3.size() != 0) begin
          chk("w8r3_result", 64'({t3, co3, s3}), 64'(q3.pop_front()));
          ret3++;
        end
      end
      if (v1 && rdy1) begin q1.push_back(model8(a8, b8, cin8, sub8, tag8)); acc1++; end
      if (v3 && rdy3) begin q3.push_back(model8(a8, b8, cin8, sub8, tag8)); acc3++; end
      @(posedge clk); #1;
      cyc++;
    end
    chk("w8r1_count", 64'(ret1), 64'd1000);
    chk("w8r3_count", 64'(ret3), 64'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
